// File: rtl/fpu_mul_out_pkg.sv
// fpu_mul_out_pkg
//   Shared constants, the buffered result entry type and the IEEE-754 packing
//   helper used by the multiply output buffer.
//   Contents:
//     EXC_*        exception flag bit positions within the 5-bit exc field
//     DBL_EXP_W,
//     SGL_EXP_W    exponent widths for double / single results
//     SGL_FRAC_*   slice of the 52-bit fraction that carries a single fraction
//     res_entry_t  one buffered entry {data, id, exc}
//     pack_result  builds the 64-bit result word from sign/exp/frac
package fpu_mul_out_pkg;

   localparam int EXC_W        = 5;
   localparam int EXC_NV       = 4;
   localparam int EXC_OF       = 3;
   localparam int EXC_UF       = 2;
   localparam int EXC_DZ       = 1;
   localparam int EXC_NX       = 0;

   localparam int DBL_EXP_W    = 11;
   localparam int SGL_EXP_W    = 8;
   localparam int FRAC_W       = 52;
   localparam int SGL_FRAC_MSB = 51;
   localparam int SGL_FRAC_LSB = 29;
   localparam int RES_W        = 64;

   // Id width carried in the stored entry; the top's ID_W must match it.
   localparam int RES_ID_W     = 5;

   typedef struct packed {
      logic [RES_W-1:0]    data;
      logic [RES_ID_W-1:0] id;
      logic [EXC_W-1:0]    exc;
   } res_entry_t;

   // Single results occupy the upper word; the low 32 bits are zero.
   function automatic logic [RES_W-1:0] pack_result(
      input logic                 sign,
      input logic [DBL_EXP_W-1:0] exp_in,
      input logic [FRAC_W-1:0]    frac_in,
      input logic                 dbl
   );
      if (dbl) begin
         return {sign, exp_in, frac_in};
      end
      return {sign, exp_in[SGL_EXP_W-1:0],
              frac_in[SGL_FRAC_MSB:SGL_FRAC_LSB], 32'h0};
   endfunction

endpackage

// File: rtl/fpu_mul_out_buf_if.sv
// fpu_mul_out_buf_if
//   Bundles the multiply-result capture side and the arbiter handshake side
//   of the multiply output buffer.
//   Modports:
//     master  the environment: multiply pipe stage 6 and the FPU output arbiter
//     slave   the buffer itself
//   Signals:
//     mul_res_vld/sign/exp/frac/dbl/id/exc  result from the multiply pipe
//     mul_flush                             discard everything buffered
//     mul_step                              pipe advance enable (to upstream)
//     mul_out_req/data/id/exc, fpu_out_rdy  head entry handshake with arbiter
//     mul_out_cnt                           occupancy
interface fpu_mul_out_buf_if
   import fpu_mul_out_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int ID_W  = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 mul_res_vld;
   logic                 mul_sign_out;
   logic [DBL_EXP_W-1:0] mul_exp_out;
   logic [FRAC_W-1:0]    mul_frac_out;
   logic                 mul_res_dbl;
   logic [ID_W-1:0]      mul_res_id;
   logic [EXC_W-1:0]     mul_res_exc;
   logic                 mul_flush;
   logic                 fpu_out_rdy;

   logic                 mul_step;
   logic                 mul_out_req;
   logic [RES_W-1:0]     mul_out_data;
   logic [ID_W-1:0]      mul_out_id;
   logic [EXC_W-1:0]     mul_out_exc;
   logic [CW-1:0]        mul_out_cnt;

   modport master (
      output mul_res_vld, mul_sign_out, mul_exp_out, mul_frac_out,
             mul_res_dbl, mul_res_id, mul_res_exc, mul_flush, fpu_out_rdy,
      input  mul_step, mul_out_req, mul_out_data, mul_out_id, mul_out_exc,
             mul_out_cnt
   );

   modport slave (
      input  mul_res_vld, mul_sign_out, mul_exp_out, mul_frac_out,
             mul_res_dbl, mul_res_id, mul_res_exc, mul_flush, fpu_out_rdy,
      output mul_step, mul_out_req, mul_out_data, mul_out_id, mul_out_exc,
             mul_out_cnt
   );

endinterface

// File: rtl/fpu_mul_out_fifo.sv
// fpu_mul_out_fifo
//   Generic DEPTH x W FIFO with synchronous flush and asynchronous reset.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     push, pop  write din at tail / drop head; caller never overflows or
//                underflows it
//     flush      empties the FIFO next cycle; outranks push and pop
//     din        entry to write
//     head       entry at the read pointer (combinational read)
//     cnt        occupancy, 0..DEPTH
module fpu_mul_out_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [CW-1:0] cnt
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] cnt_reg;

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         unique case ({push, pop})
            2'b10:   cnt_reg <= cnt_reg + CW'(1);
            2'b01:   cnt_reg <= cnt_reg - CW'(1);
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   // Storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg] <= din;
   end

   assign head = mem[rd_ptr_reg];
   assign cnt  = cnt_reg;

endmodule

// File: rtl/fpu_mul_out_buf.sv
// fpu_mul_out_buf
//   Last stage of the multiply pipe. Packs each completed multiply result into
//   IEEE-754 format, queues it, and offers it to the FPU output arbiter. When
//   the queue is full and nothing leaves, mul_step drops so the multiply pipe
//   holds its stage-6 result instead of losing it.
//   Ports:
//     rclk  clock, rising edge
//     arst  asynchronous active-high reset
//     bus   fpu_mul_out_buf_if.slave (capture side, arbiter handshake, step,
//           occupancy)
module fpu_mul_out_buf
   import fpu_mul_out_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int ID_W  = RES_ID_W
) (
   input logic               rclk,
   input logic               arst,
   fpu_mul_out_buf_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   res_entry_t    wr_entry;
   res_entry_t    head_entry;
   logic [CW-1:0] cnt;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          step;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));

   // A head leaving this cycle frees a slot for the incoming result even when
   // full. Flush also lets the pipe advance: the flush-cycle result is dropped.
   assign pop  = bus.mul_out_req & bus.fpu_out_rdy;
   assign step = ~full | pop | bus.mul_flush;
   assign push = bus.mul_res_vld & step & ~bus.mul_flush;

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = pack_result(bus.mul_sign_out, bus.mul_exp_out,
                                  bus.mul_frac_out, bus.mul_res_dbl);
      wr_entry.id   = RES_ID_W'(bus.mul_res_id);
      wr_entry.exc  = bus.mul_res_exc;
   end

   fpu_mul_out_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(res_entry_t))
   ) u_fifo (
      .clk   (rclk),
      .rst   (arst),
      .push  (push),
      .pop   (pop),
      .flush (bus.mul_flush),
      .din   (wr_entry),
      .head  (head_entry),
      .cnt   (cnt)
   );

   // Request comes only from registered occupancy, so a push is never visible
   // in its own cycle. Outputs read zero while nothing is held.
   assign bus.mul_step     = step;
   assign bus.mul_out_req  = ~empty;
   assign bus.mul_out_data = empty ? '0 : head_entry.data;
   assign bus.mul_out_id   = empty ? '0 : ID_W'(head_entry.id);
   assign bus.mul_out_exc  = empty ? '0 : head_entry.exc;
   assign bus.mul_out_cnt  = cnt;

   a_cnt_range : assert property (@(posedge rclk) disable iff (arst)
      cnt <= CW'(DEPTH));

   a_head_stable : assert property (@(posedge rclk) disable iff (arst)
      (bus.mul_out_req && !bus.fpu_out_rdy && !bus.mul_flush)
         |=> $stable(bus.mul_out_data));

endmodule

// File: tb/tb_fpu_mul_out_buf.sv
module tb_fpu_mul_out_buf;

   localparam int DEPTH = 2;
   localparam int ID_W  = 5;

   typedef struct {
      bit              sign;
      bit [10:0]       exp;
      bit [51:0]       frac;
      bit              dbl;
      bit [ID_W-1:0]   id;
      bit [4:0]        exc;
   } res_t;

   typedef struct {
      bit [63:0]       data;
      bit [ID_W-1:0]   id;
      bit [4:0]        exc;
   } exp_t;

   logic rclk = 1'b0;
   logic arst = 1'b1;

   fpu_mul_out_buf_if #(.DEPTH(DEPTH), .ID_W(ID_W)) bus ();

   fpu_mul_out_buf #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .rclk (rclk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 rclk = ~rclk;

   res_t src_q[$];     // upstream results waiting to be accepted
   exp_t exp_q[$];     // scoreboard: what the buffer should hold, in order
   int   model_cnt = 0;
   int   checks    = 0;
   int   errors    = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endfunction

   // Reference packing from the format rules, written with shifts.
   function automatic exp_t model(res_t r);
      exp_t e;
      bit [63:0] d;
      d = 64'(r.sign) << 63;
      if (r.dbl)
         d = d | (64'(r.exp) << 52) | 64'(r.frac);
      else
         d = d | (64'(r.exp & 11'h0FF) << 55) | ((64'(r.frac) >> 29) << 32);
      e.data = d;
      e.id   = r.id;
      e.exc  = r.exc;
      return e;
   endfunction

   function automatic res_t mk(bit s, bit [10:0] ex, bit [51:0] fr, bit dbl,
                               bit [ID_W-1:0] id, bit [4:0] exc);
      res_t r;
      r.sign = s; r.exp = ex; r.frac = fr; r.dbl = dbl; r.id = id; r.exc = exc;
      return r;
   endfunction

   function automatic res_t rand_res();
      return mk(1'($urandom), 11'($urandom), {20'($urandom), 32'($urandom)},
                1'($urandom), ID_W'($urandom), 5'($urandom));
   endfunction

   // One cycle: present upstream head (held until accepted), then apply the
   // model's view of what happened at the clock edge.
   task automatic tick(input bit flush, input bit rdy);
      bit vld;
      bit pop;
      bit acc;
      bus.mul_flush   = flush;
      bus.fpu_out_rdy = rdy;
      if (src_q.size() > 0) begin
         bus.mul_res_vld  = 1'b1;
         bus.mul_sign_out = src_q[0].sign;
         bus.mul_exp_out  = src_q[0].exp;
         bus.mul_frac_out = src_q[0].frac;
         bus.mul_res_dbl  = src_q[0].dbl;
         bus.mul_res_id   = src_q[0].id;
         bus.mul_res_exc  = src_q[0].exc;
      end else begin
         bus.mul_res_vld  = 1'b0;
      end
      @(posedge rclk);
      vld = (src_q.size() > 0);
      if (arst) begin
         model_cnt = 0;
      end else if (flush) begin
         exp_q.delete();
         model_cnt = 0;
         if (vld) void'(src_q.pop_front());
      end else begin
         pop = (model_cnt > 0) && rdy;
         acc = vld && ((model_cnt < DEPTH) || pop);
         if (pop) model_cnt--;
         if (acc) begin
            exp_q.push_back(model(src_q.pop_front()));
            model_cnt++;
         end
      end
      #1;
   endtask

   task automatic reset_now();
      arst = 1'b1;
      #1;
      chk("rst_req",  64'(bus.mul_out_req), 64'(0));
      chk("rst_cnt",  64'(bus.mul_out_cnt), 64'(0));
      chk("rst_step", 64'(bus.mul_step),    64'(1));
      chk("rst_data", bus.mul_out_data,     64'(0));
      exp_q.delete();
      src_q.delete();
      model_cnt = 0;
      bus.mul_res_vld = 1'b0;
      @(posedge rclk);
      #1;
      arst = 1'b0;
   endtask

   // Monitor: compares DUT outputs against the model each falling edge and
   // retires the head entry whenever the arbiter takes it.
   initial begin
      forever begin
         @(negedge rclk);
         chk("req",  64'(bus.mul_out_req), 64'(model_cnt != 0));
         chk("cnt",  64'(bus.mul_out_cnt), 64'(model_cnt));
         chk("step", 64'(bus.mul_step),
             64'((model_cnt < DEPTH) || (model_cnt > 0 && bus.fpu_out_rdy)
                 || bus.mul_flush));
         if (model_cnt != 0 && exp_q.size() != 0) begin
            chk("data", bus.mul_out_data,     exp_q[0].data);
            chk("id",   64'(bus.mul_out_id),  64'(exp_q[0].id));
            chk("exc",  64'(bus.mul_out_exc), 64'(exp_q[0].exc));
            if (bus.fpu_out_rdy && !bus.mul_flush && !arst) begin
               $display("pop id=%0d data=%h exc=%b", bus.mul_out_id,
                        bus.mul_out_data, bus.mul_out_exc);
               void'(exp_q.pop_front());
            end
         end else if (model_cnt == 0) begin
            chk("idle_data", bus.mul_out_data, 64'(0));
         end
      end
   end

   initial begin
      bus.mul_res_vld  = 1'b0;
      bus.mul_sign_out = 1'b0;
      bus.mul_exp_out  = '0;
      bus.mul_frac_out = '0;
      bus.mul_res_dbl  = 1'b0;
      bus.mul_res_id   = '0;
      bus.mul_res_exc  = '0;
      bus.mul_flush    = 1'b0;
      bus.fpu_out_rdy  = 1'b0;
      #1;
      chk("init_req",  64'(bus.mul_out_req), 64'(0));
      chk("init_cnt",  64'(bus.mul_out_cnt), 64'(0));
      chk("init_step", 64'(bus.mul_step),    64'(1));
      chk("init_data", bus.mul_out_data,     64'(0));
      chk("init_id",   64'(bus.mul_out_id),  64'(0));
      chk("init_exc",  64'(bus.mul_out_exc), 64'(0));
      @(posedge rclk);
      @(posedge rclk);
      #1;
      arst = 1'b0;

      // Double pack, popped as soon as it appears
      src_q.push_back(mk(1'b1, 11'h400, 52'h8_0000_0000_0001, 1'b1, 5'd3, 5'b00001));
      repeat (3) tick(1'b0, 1'b1);

      // Single pack
      src_q.push_back(mk(1'b0, 11'h07F, 52'hC_0000_0000_0000, 1'b0, 5'd5, 5'b10000));
      repeat (3) tick(1'b0, 1'b1);

      // Backpressure: four results against a stalled arbiter, then drain
      for (int i = 1; i <= 4; i++)
         src_q.push_back(mk(1'b0, 11'(i * 3), 52'(i) << 40, 1'b1, ID_W'(i), 5'(i)));
      repeat (4) tick(1'b0, 1'b0);
      repeat (6) tick(1'b0, 1'b1);

      // Push and pop together while full
      src_q.push_back(mk(1'b1, 11'h123, 52'hA_BCDE_F012_3456, 1'b1, 5'd6, 5'b00100));
      src_q.push_back(mk(1'b0, 11'h0AA, 52'h5_5555_5555_5555, 1'b0, 5'd7, 5'b01000));
      repeat (2) tick(1'b0, 1'b0);
      src_q.push_back(mk(1'b1, 11'h7FE, 52'hF_FFFF_FFFF_FFFF, 1'b1, 5'd8, 5'b11111));
      repeat (4) tick(1'b0, 1'b1);

      // Flush while full, with a result and a ready arbiter in the same cycle
      src_q.push_back(mk(1'b0, 11'h001, 52'h1, 1'b1, 5'd9,  5'b0));
      src_q.push_back(mk(1'b1, 11'h002, 52'h2, 1'b1, 5'd10, 5'b0));
      repeat (2) tick(1'b0, 1'b0);
      src_q.push_back(mk(1'b1, 11'h003, 52'h3, 1'b1, 5'd11, 5'b0));
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b1);

      // Reset in the middle of a burst
      src_q.push_back(mk(1'b0, 11'h010, 52'h10, 1'b1, 5'd12, 5'b0));
      src_q.push_back(mk(1'b0, 11'h020, 52'h20, 1'b0, 5'd13, 5'b0));
      src_q.push_back(mk(1'b0, 11'h030, 52'h30, 1'b1, 5'd14, 5'b0));
      repeat (2) tick(1'b0, 1'b0);
      reset_now();
      repeat (2) tick(1'b0, 1'b1);
      src_q.push_back(mk(1'b1, 11'h3FF, 52'h0_0000_2000_0000, 1'b0, 5'd15, 5'b00010));
      repeat (3) tick(1'b0, 1'b1);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) != 0 && src_q.size() < 3)
            src_q.push_back(rand_res());
         tick($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
      end

      // Drain, bounded
      for (int c = 0; c < 20 && (src_q.size() > 0 || model_cnt > 0); c++)
         tick(1'b0, 1'b1);
      chk("drained", 64'(model_cnt), 64'(0));
      tick(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
